// File: rtl/sd_spi_master.sv
// sd_spi_master
// Bus-mapped SPI master (mode 0) for the SD card slot. It exposes a small
// register window so the FAT/SD driver can talk to a real card:
//   0x0 CTRL   bit0 cs_assert (spi_cs_n = ~cs_assert)
//   0x4 DIV    [7:0] SCLK half-period minus one, in clk cycles
//   0x8 DATA   write starts an 8-bit exchange, read returns last received byte
//   0xC STATUS bit0 busy (read-only)
// DATA accesses stall (no bus_ack) while a byte is in flight, so a
// write-then-read sequence needs no polling.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   cs                 peripheral select, held until bus_ack is seen
//   bus_addr[31:0]     byte address, only [3:0] decoded
//   bus_wr_val[31:0]   write data, only [7:0] used
//   bus_bytesel[3:0]   0 = read, nonzero = write, [0] enables the update
//   bus_ack            one-cycle registered access-complete pulse
//   bus_data[31:0]     read data, zero outside the ack cycle
//   spi_sclk/mosi/miso SPI lines, SCLK idles low, MOSI idles high
//   spi_cs_n           card chip select, active low

module sd_spi_master #(
  parameter logic [7:0] CLK_DIV_RESET = 8'd63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_val,
  input  logic [3:0]  bus_bytesel,
  output logic        bus_ack,
  output logic [31:0] bus_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitCnt;
  logic [7:0]  r_divCnt;
  logic [7:0]  r_divLatch;
  logic        r_sclk;
  logic        r_mosi;
  logic [7:0]  r_rx;

  logic        r_ack;
  logic [31:0] r_busData;
  logic        r_csAssert;
  logic [7:0]  r_div;

  logic        w_busy;
  logic        w_isWrite;
  logic        w_isData;
  logic        w_accept;
  logic        w_wrEn;
  logic        w_startXfer;
  logic [31:0] w_readData;
  logic        w_unused;

  assign w_busy    = (r_state != IDLE);
  assign w_isWrite = |bus_bytesel;
  assign w_isData  = (bus_addr[3:0] == 4'h8);

  // The cycle after an ack ignores cs, so each cs assertion is one access.
  // DATA accesses are held off while a byte is in flight.
  assign w_accept    = cs & ~r_ack & ~(w_isData & w_busy);
  assign w_wrEn      = w_accept & w_isWrite & bus_bytesel[0];
  assign w_startXfer = w_wrEn & w_isData;

  assign w_unused = &{1'b0, bus_addr[31:4], bus_wr_val[31:8]};

  // Read mux for the register window; unmapped offsets read as zero.
  always_comb begin
    w_readData = '0;
    case (bus_addr[3:0])
      4'h0:    w_readData = {31'b0, r_csAssert};
      4'h4:    w_readData = {24'b0, r_div};
      4'h8:    w_readData = {24'b0, r_rx};
      4'hC:    w_readData = {31'b0, w_busy};
      default: w_readData = '0;
    endcase
  end

  // Bus side: one-cycle ack, read data captured at acceptance, and the
  // CTRL/DIV registers. CTRL is never stalled so chip select can change
  // even mid-byte; a DIV write only affects the next byte because the
  // transfer FSM works from its own latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_busData  <= '0;
      r_csAssert <= 1'b0;
      r_div      <= CLK_DIV_RESET;
    end else begin
      r_ack     <= w_accept;
      r_busData <= '0;
      if (w_accept && !w_isWrite) begin
        r_busData <= w_readData;
      end
      if (w_wrEn) begin
        case (bus_addr[3:0])
          4'h0:    r_csAssert <= bus_wr_val[0];
          4'h4:    r_div      <= bus_wr_val[7:0];
          default: ;
        endcase
      end
    end
  end

  // Transfer FSM. Each SCLK phase lasts r_divLatch+1 cycles. MISO is
  // sampled on the rising edge into the shift register LSB, and the next
  // MOSI bit (now at the MSB) is presented on the falling edge. After the
  // eighth high phase the received byte moves to rx and MOSI idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_divCnt   <= 8'd0;
      r_divLatch <= 8'd0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b1;
      r_rx       <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startXfer) begin
            r_state    <= LOW;
            r_shift    <= bus_wr_val[7:0];
            r_mosi     <= bus_wr_val[7];
            r_divLatch <= r_div;
            r_divCnt   <= r_div;
            r_bitCnt   <= 3'd0;
          end
        end
        LOW: begin
          if (r_divCnt == 8'd0) begin
            r_state  <= HIGH;
            r_sclk   <= 1'b1;
            r_shift  <= {r_shift[6:0], spi_miso};
            r_divCnt <= r_divLatch;
          end else begin
            r_divCnt <= r_divCnt - 8'd1;
          end
        end
        HIGH: begin
          if (r_divCnt == 8'd0) begin
            r_sclk   <= 1'b0;
            r_divCnt <= r_divLatch;
            if (r_bitCnt == 3'd7) begin
              r_state <= IDLE;
              r_rx    <= r_shift;
              r_mosi  <= 1'b1;
            end else begin
              r_state  <= LOW;
              r_bitCnt <= r_bitCnt + 3'd1;
              r_mosi   <= r_shift[7];
            end
          end else begin
            r_divCnt <= r_divCnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_ack  = r_ack;
  assign bus_data = r_busData;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = ~r_csAssert;

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master
// Testbench for sd_spi_master: a table of register accesses with expected
// read data and chip-select state, followed by hand-written sequences for
// byte transfers, DATA stalls, DIV changes mid-byte and reset mid-stall.
// A small SCLK monitor records edge counts, phase lengths and the MOSI bits
// seen on each rising edge.

module tb_sd_spi_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    logic        isRead;
    logic [31:0] expData;
    logic        expCsn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wr_val = '0;
  logic [3:0]  bus_bytesel = '0;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;

  logic loopback = 1'b0;
  logic misoConst = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  int rises = 0;
  int highRun = 0;
  int highMin = 1000;
  int highMax = 0;
  int periodMin = 1000;
  int periodMax = 0;
  int lastRise = -1;
  int period = 0;
  logic [15:0] mosiCap = '0;
  logic prevSclk = 1'b0;

  vec_t vecs [19];
  logic [31:0] rd;
  int s1, a1, s2, a2, s3, a3, s4, a4;
  logic sawAck;

  sd_spi_master #(.CLK_DIV_RESET(8'd63)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .bus_addr   (bus_addr),
    .bus_wr_val (bus_wr_val),
    .bus_bytesel(bus_bytesel),
    .bus_ack    (bus_ack),
    .bus_data   (bus_data),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs_n   (spi_cs_n)
  );

  assign spi_miso = loopback ? spi_mosi : misoConst;

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // SCLK monitor: counts rising edges, captures MOSI at each rise, and
  // tracks min/max high-phase length and rise-to-rise period.
  always @(posedge clk) begin
    #1;
    if (spi_sclk && !prevSclk) begin
      rises++;
      mosiCap = {mosiCap[14:0], spi_mosi};
      if (lastRise >= 0) begin
        period = cycleCount - lastRise;
        if (period < periodMin) periodMin = period;
        if (period > periodMax) periodMax = period;
      end
      lastRise = cycleCount;
      highRun = 0;
    end
    if (spi_sclk) begin
      highRun++;
    end else if (prevSclk) begin
      if (highRun < highMin) highMin = highRun;
      if (highRun > highMax) highMax = highRun;
    end
    prevSclk = spi_sclk;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic resetStats();
    rises = 0;
    highMin = 1000;
    highMax = 0;
    periodMin = 1000;
    periodMax = 0;
    lastRise = -1;
    mosiCap = '0;
  endtask

  // One bus access: hold cs until ack (bounded), capture data, then confirm
  // the ack lasted a single cycle. Returns the start cycle and ack cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] bsel, output logic [31:0] rdata,
                               output int startCyc, output int ackCyc);
    int waited;
    waited = 0;
    cs = 1'b1;
    bus_addr = addr;
    bus_wr_val = wdata;
    bus_bytesel = bsel;
    startCyc = cycleCount;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!bus_ack && waited < 3000);
    checkOutput("ack_seen", {31'b0, bus_ack}, 32'd1);
    rdata = bus_data;
    ackCyc = cycleCount;
    cs = 1'b0;
    bus_addr = '0;
    bus_wr_val = '0;
    bus_bytesel = '0;
    @(posedge clk);
    #1;
    checkOutput("ack_single_cycle", {31'b0, bus_ack}, 32'd0);
  endtask

  initial begin
    // addr, wdata, bsel, isRead, expData, expCsn
    vecs[0]  = '{32'h0,  32'h0,   4'h0, 1'b1, 32'h0,  1'b1};
    vecs[1]  = '{32'h4,  32'h0,   4'h0, 1'b1, 32'd63, 1'b1};
    vecs[2]  = '{32'h8,  32'h0,   4'h0, 1'b1, 32'h0,  1'b1};
    vecs[3]  = '{32'hC,  32'h0,   4'h0, 1'b1, 32'h0,  1'b1};
    vecs[4]  = '{32'h2,  32'h0,   4'h0, 1'b1, 32'h0,  1'b1};
    vecs[5]  = '{32'h4,  32'h1AB, 4'h1, 1'b0, 32'h0,  1'b1};
    vecs[6]  = '{32'h4,  32'h0,   4'h0, 1'b1, 32'hAB, 1'b1};
    vecs[7]  = '{32'h4,  32'h55,  4'h2, 1'b0, 32'h0,  1'b1};
    vecs[8]  = '{32'h4,  32'h0,   4'h0, 1'b1, 32'hAB, 1'b1};
    vecs[9]  = '{32'h6,  32'hFF,  4'hF, 1'b0, 32'h0,  1'b1};
    vecs[10] = '{32'h6,  32'h0,   4'h0, 1'b1, 32'h0,  1'b1};
    vecs[11] = '{32'h0,  32'h1,   4'h1, 1'b0, 32'h0,  1'b0};
    vecs[12] = '{32'h0,  32'h0,   4'h0, 1'b1, 32'h1,  1'b0};
    vecs[13] = '{32'h8,  32'h77,  4'h2, 1'b0, 32'h0,  1'b0};
    vecs[14] = '{32'hC,  32'h0,   4'h0, 1'b1, 32'h0,  1'b0};
    vecs[15] = '{32'h0,  32'h0,   4'h8, 1'b0, 32'h0,  1'b0};
    vecs[16] = '{32'h10, 32'h0,   4'h0, 1'b1, 32'h1,  1'b0};
    vecs[17] = '{32'h0,  32'h0,   4'h1, 1'b0, 32'h0,  1'b1};
    vecs[18] = '{32'h8,  32'h0,   4'h0, 1'b1, 32'h0,  1'b1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", {31'b0, bus_ack}, 32'd0);
    checkOutput("reset_data", bus_data, 32'd0);
    checkOutput("reset_sclk", {31'b0, spi_sclk}, 32'd0);
    checkOutput("reset_mosi", {31'b0, spi_mosi}, 32'd1);
    checkOutput("reset_csn", {31'b0, spi_cs_n}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resetStats();

    $display("[TB] register table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].bsel, rd, s1, a1);
      checkOutput($sformatf("vec%0d_latency", i), a1 - s1, 32'd1);
      if (vecs[i].isRead)
        checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
      checkOutput($sformatf("vec%0d_csn", i), {31'b0, spi_cs_n}, {31'b0, vecs[i].expCsn});
    end
    checkOutput("table_no_sclk", rises, 32'd0);

    $display("[TB] loopback 0xA5 at DIV=0");
    applyStimulus(32'h4, 32'h0, 4'h1, rd, s1, a1);
    applyStimulus(32'h0, 32'h1, 4'h1, rd, s1, a1);
    checkOutput("a5_csn", {31'b0, spi_cs_n}, 32'd0);
    loopback = 1'b1;
    resetStats();
    applyStimulus(32'h8, 32'hA5, 4'h1, rd, s1, a1);
    checkOutput("a5_write_latency", a1 - s1, 32'd1);
    applyStimulus(32'h8, 32'h0, 4'h0, rd, s2, a2);
    checkOutput("a5_read_stall", a2 - a1, 32'd17);
    checkOutput("a5_read_data", rd, 32'hA5);
    checkOutput("a5_rises", rises, 32'd8);
    checkOutput("a5_high_min", highMin, 32'd1);
    checkOutput("a5_high_max", highMax, 32'd1);
    checkOutput("a5_mosi_bits", {24'b0, mosiCap[7:0]}, 32'hA5);
    checkOutput("a5_mosi_idle", {31'b0, spi_mosi}, 32'd1);
    checkOutput("a5_sclk_idle", {31'b0, spi_sclk}, 32'd0);

    $display("[TB] 0xFF at DIV=3 with MISO low");
    applyStimulus(32'h4, 32'h3, 4'h1, rd, s1, a1);
    loopback = 1'b0;
    misoConst = 1'b0;
    resetStats();
    applyStimulus(32'h8, 32'hFF, 4'h1, rd, s1, a1);
    applyStimulus(32'h8, 32'h0, 4'h0, rd, s2, a2);
    checkOutput("ff_read_stall", a2 - a1, 32'd65);
    checkOutput("ff_read_data", rd, 32'h00);
    checkOutput("ff_rises", rises, 32'd8);
    checkOutput("ff_high_min", highMin, 32'd4);
    checkOutput("ff_high_max", highMax, 32'd4);
    checkOutput("ff_period_min", periodMin, 32'd8);
    checkOutput("ff_period_max", periodMax, 32'd8);
    checkOutput("ff_mosi_bits", {24'b0, mosiCap[7:0]}, 32'hFF);

    $display("[TB] back-to-back 0x12, 0x34 at DIV=0");
    applyStimulus(32'h4, 32'h0, 4'h1, rd, s1, a1);
    loopback = 1'b1;
    resetStats();
    applyStimulus(32'h8, 32'h12, 4'h1, rd, s1, a1);
    applyStimulus(32'hC, 32'h0, 4'h0, rd, s2, a2);
    checkOutput("b2b_status_busy", rd, 32'd1);
    checkOutput("b2b_status_latency", a2 - s2, 32'd1);
    applyStimulus(32'h8, 32'h34, 4'h1, rd, s3, a3);
    checkOutput("b2b_write_stall", a3 - a1, 32'd17);
    applyStimulus(32'h8, 32'h0, 4'h0, rd, s4, a4);
    checkOutput("b2b_read_stall", a4 - a3, 32'd17);
    checkOutput("b2b_read_data", rd, 32'h34);
    checkOutput("b2b_rises", rises, 32'd16);
    checkOutput("b2b_high_max", highMax, 32'd1);
    checkOutput("b2b_period_min", periodMin, 32'd2);
    checkOutput("b2b_period_max", periodMax, 32'd3);
    checkOutput("b2b_mosi_bits", {16'b0, mosiCap}, 32'h1234);

    $display("[TB] DIV change mid-transfer");
    resetStats();
    applyStimulus(32'h8, 32'h5A, 4'h1, rd, s1, a1);
    applyStimulus(32'h4, 32'h7, 4'h1, rd, s2, a2);
    checkOutput("divchg_div_latency", a2 - s2, 32'd1);
    applyStimulus(32'h8, 32'hC3, 4'h1, rd, s3, a3);
    checkOutput("divchg_write_stall", a3 - a1, 32'd17);
    checkOutput("divchg_b1_rises", rises, 32'd8);
    checkOutput("divchg_b1_high_max", highMax, 32'd1);
    checkOutput("divchg_b1_period_max", periodMax, 32'd2);
    checkOutput("divchg_b1_mosi", {24'b0, mosiCap[7:0]}, 32'h5A);
    resetStats();
    applyStimulus(32'h8, 32'h0, 4'h0, rd, s4, a4);
    checkOutput("divchg_read_stall", a4 - a3, 32'd129);
    checkOutput("divchg_read_data", rd, 32'hC3);
    checkOutput("divchg_b2_rises", rises, 32'd8);
    checkOutput("divchg_b2_high_min", highMin, 32'd8);
    checkOutput("divchg_b2_high_max", highMax, 32'd8);
    checkOutput("divchg_b2_period_min", periodMin, 32'd16);
    checkOutput("divchg_b2_period_max", periodMax, 32'd16);
    checkOutput("divchg_b2_mosi", {24'b0, mosiCap[7:0]}, 32'hC3);

    $display("[TB] reset during stalled DATA read");
    applyStimulus(32'h0, 32'h1, 4'h1, rd, s1, a1);
    applyStimulus(32'h8, 32'h81, 4'h1, rd, s1, a1);
    sawAck = 1'b0;
    cs = 1'b1;
    bus_addr = 32'h8;
    bus_bytesel = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      sawAck = sawAck | bus_ack;
    end
    checkOutput("rst_stall_no_ack", {31'b0, sawAck}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ack", {31'b0, bus_ack}, 32'd0);
    checkOutput("rst_data", bus_data, 32'd0);
    checkOutput("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    checkOutput("rst_mosi", {31'b0, spi_mosi}, 32'd1);
    checkOutput("rst_csn", {31'b0, spi_cs_n}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sawAck = sawAck | bus_ack;
    end
    checkOutput("rst_hold_no_ack", {31'b0, sawAck}, 32'd0);
    cs = 1'b0;
    bus_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_release_no_ack", {31'b0, bus_ack}, 32'd0);
    applyStimulus(32'hC, 32'h0, 4'h0, rd, s1, a1);
    checkOutput("rst_status", rd, 32'd0);
    checkOutput("rst_status_latency", a1 - s1, 32'd1);
    applyStimulus(32'h4, 32'h0, 4'h0, rd, s1, a1);
    checkOutput("rst_div", rd, 32'd63);
    applyStimulus(32'h0, 32'h0, 4'h0, rd, s1, a1);
    checkOutput("rst_ctrl", rd, 32'd0);
    applyStimulus(32'h8, 32'h0, 4'h0, rd, s1, a1);
    checkOutput("rst_rx", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
